// File: rtl/gb_stream_arbiter_pkg.sv
// Shared definitions for the gray-balance stream arbiter family:
// controller state encodings and Avalon-ST video packet type codes.
package gb_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_GRANT = 3'b010,
        ST_PASS  = 3'b100
    } gb_state_e;

    // Packet type nibble carried in the SOP beat (low bits of colour plane 0)
    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam logic [3:0] PKT_CTRL  = 4'hF;

    // A frame ends only on the EOP of a video-data packet
    function automatic logic isFrameEnd(input logic [3:0] pktType);
        return (pktType == PKT_VIDEO);
    endfunction

endpackage

// File: rtl/gb_stream_arbiter_rr_pick.sv
// Two-way round-robin picker: when both inputs request, the one that did
// not win last time is chosen; a lone requester always wins.
module gb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       any_o
);

    // Winner index and request-present flag
    always_comb begin
        any_o = |req_i;
        if (&req_i) begin
            grant_o = ~last_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/gb_stream_arbiter.sv
// Frame-granular two-input Avalon-ST video arbiter. A granted source keeps
// the output until the EOP of a video-data packet; the datapath is a
// zero-latency mux, the controller a small registered FSM.
module gb_stream_arbiter
    import gb_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int COLOR_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din0_data,
    input  logic                  din0_valid,
    input  logic                  din0_startofpacket,
    input  logic                  din0_endofpacket,
    output logic                  din0_ready,
    input  logic [DATA_WIDTH-1:0] din1_data,
    input  logic                  din1_valid,
    input  logic                  din1_startofpacket,
    input  logic                  din1_endofpacket,
    output logic                  din1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    input  logic [1:0]            src_enable,
    output logic                  cur_sel,
    output logic                  busy
);

    // Plane 0 occupies the lowest COLOR_BITS bits; its bottom nibble is the type
    localparam int TYPE_LSB = COLOR_BITS * 0;

    gb_state_e             state_q, state_d;
    logic                  curSel_q, curSel_d;
    logic [3:0]            pktType_q, pktType_d;

    logic [1:0]            req;
    logic                  pickGrant;
    logic                  pickAny;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selValid;
    logic                  selSop;
    logic                  selEop;
    logic [3:0]            beatType;

    assign req[0] = din0_valid & din0_startofpacket & src_enable[0];
    assign req[1] = din1_valid & din1_startofpacket & src_enable[1];

    gb_rr_pick u_pick (
        .req_i   (req),
        .last_i  (curSel_q),
        .grant_o (pickGrant),
        .any_o   (pickAny)
    );

    // Source mux for the granted input; single-beat packets take their own type
    always_comb begin
        selData  = curSel_q ? din1_data          : din0_data;
        selValid = curSel_q ? din1_valid         : din0_valid;
        selSop   = curSel_q ? din1_startofpacket : din0_startofpacket;
        selEop   = curSel_q ? din1_endofpacket   : din0_endofpacket;
        beatType = selSop ? selData[TYPE_LSB +: 4] : pktType_q;
    end

    // Controller state, grant index and current packet type
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            curSel_q  <= 1'b1;
            pktType_q <= PKT_VIDEO;
        end else begin
            state_q   <= state_d;
            curSel_q  <= curSel_d;
            pktType_q <= pktType_d;
        end
    end

    // Next-state, handshakes and output datapath
    always_comb begin
        state_d            = state_q;
        curSel_d           = curSel_q;
        pktType_d          = pktType_q;
        din0_ready         = 1'b0;
        din1_ready         = 1'b0;
        dout_data          = '0;
        dout_valid         = 1'b0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                din0_ready = rst_n & din0_valid & ~req[0];
                din1_ready = rst_n & din1_valid & ~req[1];
                if (pickAny) begin
                    curSel_d = pickGrant;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_PASS;
            end
            ST_PASS: begin
                dout_data          = selData;
                dout_valid         = selValid;
                dout_startofpacket = selSop;
                dout_endofpacket   = selEop;
                if (curSel_q) begin
                    din1_ready = dout_ready;
                end else begin
                    din0_ready = dout_ready;
                end
                if (selValid && dout_ready) begin
                    if (selSop) begin
                        pktType_d = selData[TYPE_LSB +: 4];
                    end
                    if (selEop && isFrameEnd(beatType)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cur_sel = curSel_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gb_stream_arbiter.sv
// Self-checking bench for gb_stream_arbiter. Sources replay queued frames;
// the expected output stream is built at generation time from the
// frame-level arbitration rules (whole frames, alternating sources).
module tb_gb_stream_arbiter;

    localparam int DW = 14;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          first;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din0_data = '0;
    logic          din0_valid = 1'b0;
    logic          din0_startofpacket = 1'b0;
    logic          din0_endofpacket = 1'b0;
    logic          din0_ready;
    logic [DW-1:0] din1_data = '0;
    logic          din1_valid = 1'b0;
    logic          din1_startofpacket = 1'b0;
    logic          din1_endofpacket = 1'b0;
    logic          din1_ready;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_startofpacket;
    logic          dout_endofpacket;
    logic          dout_ready = 1'b0;
    logic [1:0]    src_enable = 2'b11;
    logic          cur_sel;
    logic          busy;

    beat_t      srcQ0[$];
    beat_t      srcQ1[$];
    beat_t      expQ[$];
    beat_t      outQ[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         acc0 = 0;
    bit         acc1 = 0;
    int         readyPct = 100;
    int         gapPct = 0;
    logic [3:0] outType = 4'h0;
    bit         pendIdle = 0;
    bit         prevStall = 0;
    logic [8:0] seq0 = '0;
    logic [8:0] seq1 = '0;

    gb_stream_arbiter #(.DATA_WIDTH(DW), .COLOR_BITS(14)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .din0_data          (din0_data),
        .din0_valid         (din0_valid),
        .din0_startofpacket (din0_startofpacket),
        .din0_endofpacket   (din0_endofpacket),
        .din0_ready         (din0_ready),
        .din1_data          (din1_data),
        .din1_valid         (din1_valid),
        .din1_startofpacket (din1_startofpacket),
        .din1_endofpacket   (din1_endofpacket),
        .din1_ready         (din1_ready),
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket),
        .dout_ready         (dout_ready),
        .src_enable         (src_enable),
        .cur_sel            (cur_sel),
        .busy               (busy)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it when it differs
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue one packet on a source; data = {source, sequence, low nibble}
    task automatic genPacket(input int s, input logic [3:0] ptype, input int len,
                             input bit first, input bit expectOut);
        beat_t      b;
        logic [3:0] low;
        logic [8:0] seq;
        logic       srcBit;
        srcBit = (s != 0);
        for (int i = 0; i < len; i++) begin
            low = (i == 0) ? ptype : 4'($urandom);
            seq = srcBit ? seq1 : seq0;
            if (srcBit) seq1++; else seq0++;
            b.data  = {srcBit, seq, low};
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.first = first && (i == 0);
            if (srcBit) srcQ1.push_back(b); else srcQ0.push_back(b);
            if (expectOut) expQ.push_back(b);
        end
    endtask

    // A frame: up to two control/user packets followed by one video packet
    task automatic genFrame(input int s);
        int         n;
        logic [3:0] t;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            t = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 14));
            genPacket(s, t, $urandom_range(1, 5), k == 0, 1'b1);
        end
        genPacket(s, 4'h0, $urandom_range(1, 6), n == 0, 1'b1);
    endtask

    // One clock: drive sources after the edge, sample and check mid-cycle
    task automatic applyStimulus(input bit pulseReset);
        int idx;
        @(posedge clk);
        #1;
        if (acc0) void'(srcQ0.pop_front());
        if (!(din0_valid && !acc0)) begin
            if (srcQ0.size() == 0 || (!srcQ0[0].first && $urandom_range(99) < gapPct)) begin
                din0_valid = 1'b0;
            end else begin
                din0_valid         = 1'b1;
                din0_data          = srcQ0[0].data;
                din0_startofpacket = srcQ0[0].sop;
                din0_endofpacket   = srcQ0[0].eop;
            end
        end
        if (acc1) void'(srcQ1.pop_front());
        if (!(din1_valid && !acc1)) begin
            if (srcQ1.size() == 0 || (!srcQ1[0].first && $urandom_range(99) < gapPct)) begin
                din1_valid = 1'b0;
            end else begin
                din1_valid         = 1'b1;
                din1_data          = srcQ1[0].data;
                din1_startofpacket = srcQ1[0].sop;
                din1_endofpacket   = srcQ1[0].eop;
            end
        end
        dout_ready = ($urandom_range(99) < readyPct);
        if (pulseReset) begin
            rst_n = 1'b0;
            #2;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_cur_sel", cur_sel, 1);
            checkOutput("rst_dout_valid", dout_valid, 0);
            checkOutput("rst_din0_ready", din0_ready, 0);
            checkOutput("rst_din1_ready", din1_ready, 0);
            pendIdle  = 0;
            prevStall = 0;
        end
        @(negedge clk);
        acc0 = din0_valid & din0_ready;
        acc1 = din1_valid & din1_ready;
        if (pendIdle) checkOutput("busy_after_video_eop", busy, 0);
        pendIdle = 0;
        if (prevStall) checkOutput("stall_valid_held", dout_valid, 1);
        if (dout_valid) begin
            idx = outQ.size();
            checkOutput("beat_expected", idx < expQ.size(), 1);
            if (idx < expQ.size()) begin
                checkOutput("dout_beat", {dout_data, dout_startofpacket, dout_endofpacket},
                            {expQ[idx].data, expQ[idx].sop, expQ[idx].eop});
            end
            checkOutput("busy_in_pass", busy, 1);
            checkOutput("cur_sel_owner", cur_sel, dout_data[DW-1]);
            checkOutput("other_ready", dout_data[DW-1] ? din0_ready : din1_ready, 0);
        end
        prevStall = dout_valid & ~dout_ready;
        if (dout_valid && dout_ready) begin
            outQ.push_back({dout_data, dout_startofpacket, dout_endofpacket, 1'b0});
            if (dout_startofpacket) outType = dout_data[3:0];
            if (dout_endofpacket && ((dout_startofpacket ? dout_data[3:0] : outType) == 4'h0))
                pendIdle = 1;
        end
        if (pulseReset) rst_n = 1'b1;
    endtask

    // Step until both sources are empty, bounded by a cycle budget
    task automatic runUntilIdle(input int budget);
        int n = 0;
        while ((srcQ0.size() != 0 || srcQ1.size() != 0 || din0_valid || din1_valid) && n < budget) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput("drain_in_budget", n < budget, 1);
    endtask

    // Close a scenario: all expected beats seen, then clear the scoreboard
    task automatic endTest(input string tag);
        checkOutput(tag, outQ.size(), expQ.size());
        outQ.delete();
        expQ.delete();
    endtask

    // Directed scenarios followed by a randomized two-source run
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cur_sel", cur_sel, 1);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_din0_ready", din0_ready, 0);
        checkOutput("reset_din1_ready", din1_ready, 0);
        rst_n = 1'b1;

        // Source 0 alone: control then video, full-rate output
        genPacket(0, 4'hF, 10, 1'b1, 1'b1);
        genPacket(0, 4'h0, 16, 1'b0, 1'b1);
        runUntilIdle(200);
        checkOutput("A_cur_sel", cur_sel, 0);
        checkOutput("A_busy_end", busy, 0);
        endTest("A_beat_count");

        // Disabled source 1 is drained, then granted once enabled
        src_enable = 2'b01;
        genPacket(1, 4'hF, 2, 1'b1, 1'b0);
        genPacket(1, 4'h0, 3, 1'b0, 1'b0);
        applyStimulus(1'b0);
        checkOutput("B_drain_ready", din1_ready, 1);
        checkOutput("B_no_output", dout_valid, 0);
        runUntilIdle(100);
        checkOutput("B_busy_idle", busy, 0);
        endTest("B_drain_count");
        src_enable = 2'b11;
        genPacket(1, 4'h0, 4, 1'b1, 1'b1);
        runUntilIdle(100);
        checkOutput("B_cur_sel", cur_sel, 1);
        endTest("B_grant_count");

        // Reset during the 5th beat of a video packet, then resync
        genPacket(0, 4'h0, 12, 1'b1, 1'b1);
        while (expQ.size() > 4) void'(expQ.pop_back());
        for (int n = 0; n < 50 && outQ.size() < 4; n++) applyStimulus(1'b0);
        applyStimulus(1'b1);
        runUntilIdle(100);
        checkOutput("C_busy_after_drain", busy, 0);
        endTest("C_partial_count");
        genPacket(0, 4'hF, 1, 1'b1, 1'b1);
        genPacket(0, 4'h0, 2, 1'b0, 1'b1);
        runUntilIdle(100);
        checkOutput("C_cur_sel", cur_sel, 0);
        endTest("C_regrant_count");

        // Both sources always offering frames: strict alternation from src0
        applyStimulus(1'b1);
        readyPct = 60;
        gapPct   = 25;
        for (int f = 0; f < 8; f++) begin
            genFrame(0);
            genFrame(1);
        end
        runUntilIdle(4000);
        endTest("D_random_count");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gb_stream_arbiter.md
Name: gb_stream_arbiter

Overview:
Two-input Avalon-ST video arbiter that shares one downstream video pipeline (gray-balance decode/processing chain) between two sources. Grants are frame-granular: once an input is granted, all of its packets (control, user, video) pass until the end of a video-data packet. Only then is the output re-arbitrated, round-robin, among enabled inputs. The datapath is combinational; the controller is a registered FSM. Sits in front of the stream decoder so the decoder always sees well-formed control/video sequences from a single source.

Parameters:
DATA_WIDTH, 14, width of every data bus (COLOR_BITS*COLOR_PLANES)
COLOR_BITS, 14, bits per colour plane; packet type is data[3:0] of plane 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
din0_data  in  DATA_WIDTH  source 0 data
din0_valid  in  1  source 0 valid
din0_startofpacket  in  1  source 0 SOP
din0_endofpacket  in  1  source 0 EOP
din0_ready  out  1  source 0 ready
din1_data / din1_valid / din1_startofpacket / din1_endofpacket / din1_ready: same as source 0, for source 1
dout_data  out  DATA_WIDTH  granted source data
dout_valid  out  1  output valid
dout_startofpacket  out  1  output SOP
dout_endofpacket  out  1  output EOP
dout_ready  in  1  downstream ready
src_enable  in  2  per-input enable mask, bit i = din i
cur_sel  out  1  currently/last granted input
busy  out  1  high while a grant is held

Behaviour:
- Beat accepted on input i = dini_valid & dini_ready; on output = dout_valid & dout_ready.
- States: IDLE, GRANT, PASS. Reset: state=IDLE, cur_sel=1 (so input 0 wins first), busy=0, pkt_type=0. All outputs low at reset except cur_sel=1.
- IDLE:
  - req_i = dini_valid & dini_startofpacket & src_enable[i].
  - Input i with valid & !SOP, or with SOP while disabled, gets dini_ready=1 and its beat is discarded (resync).
  - Inputs presenting a valid SOP hold ready=0.
  - If any req_i: pick winner, register cur_sel, go to GRANT.
  - With both requesting, winner = !cur_sel (round-robin). With one requesting, that input wins.
- GRANT: one-cycle bubble; dout_valid=0 and all dini_ready=0. Next state PASS, busy=1.
- PASS:
  - Combinational pass-through: dout_* = selected din_*, dout_valid = sel valid, sel ready = dout_ready. Non-selected ready=0.
  - Zero latency through the datapath; no buffering.
  - On each accepted SOP beat, latch pkt_type = data[3:0].
  - On an accepted EOP beat:
    - pkt_type==4'h0 (video): go to IDLE, busy=0 next cycle.
    - Any other type (4'hF control, user packets): stay in PASS.
  - A single-beat packet (SOP and EOP in the same beat) uses the type from that same beat.
- src_enable changes take effect only at arbitration time; deasserting the enable of the granted input mid-frame does not abort the frame.
- dout_ready low stalls everything with no state change; the grant is held indefinitely.
- Asynchronous reset mid-frame: immediate return to IDLE with ready=0. The remainder of the interrupted packet is discarded by IDLE resync.
- busy = (state != IDLE). cur_sel keeps its last value in IDLE.

Decomposition:
- Shared package gb_pkg: state encodings (one-hot IDLE/GRANT/PASS), PKT_VIDEO=4'h0, PKT_CTRL=4'hF.
- One sub-module: gb_rr_pick, a 2-way round-robin picker (req[1:0], last → grant index, any). Reusable by later N-input variants.

Test Plan:
- Src0 only, enable=2'b11: control packet (type F, 10 beats) then video packet (type 0, 16 beats), dout_ready=1 → 26 output beats identical to input. cur_sel=0. busy falls the cycle after the video EOP. din1_ready stays 0 throughout.
- Both inputs present SOP in the same cycle from reset → src0 frame first, then src1, then src0 again. cur_sel sequence 0,1,0.
- Src1 sends control packet, then src0 raises SOP mid-control → src0 is held off (din0_ready=0) until src1's video EOP is accepted.
- enable=2'b01 with only src1 sending SOP → src1 beats are drained (din1_ready=1), dout_valid=0. Raising enable to 2'b11 → the next src1 SOP is granted.
- Src0 video packet with dout_ready toggling 1,0,0,1 → no beat lost or duplicated; valid/data held stable while stalled.
- rst_n pulsed low during the 5th beat of a video packet → state=IDLE, busy=0. Remaining non-SOP beats are drained. The next SOP is granted normally.
